spi_adc_model_multi: RTL
========================

Name: spi_adc_model_multi

Overview:
Parametrised, cycle-accurate behavioural model of the multi-channel SPI A2D converter on the DE0 board. It replaces the fixed ADC128S model in the Segway system bench. Each channel holds a programmable value, either static or auto-ramping, which feeds the DUT's load-cell/battery A2D interface. It uses the ADC128S-style two-frame protocol: the channel is addressed in frame N and its data is returned in frame N+1.

Parameters:
NUM_CH, 8, number of channels (1..8).
RES, 12, conversion resolution in bits (1..16). The returned word is {(16-RES) zeros, value}.
FRAME, 16, SCLK rising edges per valid frame.
ADDR_LSB, 11, MOSI bit position of the channel field LSB. The field is 3 bits wide: [ADDR_LSB+2:ADDR_LSB].

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
SS_n  in  1  SPI select from DUT, asynchronous to clk
SCLK  in  1  SPI clock from DUT, slower than clk/8
MOSI  in  1  SPI data from DUT
MISO  out  1  SPI data to DUT
ch_wr  in  1  host write strobe, one clk
ch_sel  in  3  host channel select
ch_val  in  RES  host value
ch_mode  in  2  00 static, 01 ramp-wrap, 10 ramp-saturate, 11 reserved (treated as static)
ch_step  in  RES  ramp increment
conv_cnt  out  16  count of valid frames
frame_err  out  1  one-clk pulse when a frame is short or long
bad_ch  out  1  sticky flag: a channel address >= NUM_CH was received

Behaviour:
- Reset (rst_n low at a clk edge):
  - All channel values, modes and steps cleared to 0.
  - Pointer = 0, shift registers = 0, bit count = 0.
  - MISO = 0, conv_cnt = 0, frame_err = 0, bad_ch = 0.
  - Reset mid-frame abandons the frame. Nothing updates until the next SS_n fall.
- Input synchronisation: SS_n, SCLK and MOSI each pass through a 2-flop synchroniser. Edges are detected on the synchronised copies, so the response lags the pin edge by 2–3 clk.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on SS_n fall.
    - tx_shift = {zeros, val[ptr]}.
    - MISO = tx_shift[15] from the next clk.
    - bit count = 0.
  - In SHIFT, on each SCLK rise:
    - rx_shift = {rx_shift[14:0], MOSI}.
    - bit count +1, saturating at 31.
  - In SHIFT, on each SCLK fall: tx_shift shifts left and MISO takes the new MSB. Before the first rise, MISO holds bit 15.
  - SHIFT -> DONE on SS_n rise. DONE lasts 1 clk, then -> IDLE.
    - If bit count == FRAME (valid frame):
      - ptr = rx_shift[ADDR_LSB+2:ADDR_LSB].
      - conv_cnt +1, wrapping at 2^16.
      - If the channel just returned is in ramp mode, update its value.
      - If the address >= NUM_CH, set bad_ch. ptr is still loaded; that channel reads 0.
    - If bit count != FRAME: frame_err pulses, and ptr, ramp and conv_cnt are unchanged.
  - In IDLE, MISO = 0.
- Ramp arithmetic, in RES bits:
  - wrap: v = (v + step) mod 2^RES.
  - saturate: v = min(v + step, 2^RES - 1), computed with a RES+1-bit sum.
  - The ramp applies to the channel whose data was shifted out in the completed frame, not the newly addressed one.
- Host writes:
  - ch_wr loads val, mode and step for ch_sel < NUM_CH. Writes with ch_sel >= NUM_CH are ignored.
  - The data for the current frame is latched at SS_n fall, so a write mid-frame affects the next frame only.
  - A host write and a ramp update to the same channel in the same clk: the write wins.
- If SS_n and SCLK edges are detected in the same clk, the SS_n edge takes priority.

Decomposition:
- Package adc_model_pkg holds:
  - the mode enum (MODE_STATIC, MODE_RAMP_WRAP, MODE_RAMP_SAT);
  - the FSM state enum;
  - the constant FRAME_BITS = 16.
- One sub-module, adc_spi_slave_shift, contains the synchronisers, edge detect, shift registers, bit count and FSM. It exposes:
  - outputs frame_start, frame_ok, frame_bad, rx_word;
  - input tx_word.
- The top level holds the channel register file, the ramp logic and the counters.

Test Plan:
- Write ch2 = 0xA5C static. Frame 1 sends MOSI 0x1000 (ch2). Frame 2 returns MISO 0x0A5C and conv_cnt = 2.
- Write ch5 = 0xFFE, mode ramp-wrap, step 3. Three consecutive frames addressing ch5 return 0x000 (reset ptr 0), 0xFFE, 0x001.
- Write ch1 = 0xFF0, mode ramp-saturate, step 0x20. Repeated ch1 reads return 0xFF0, then 0xFFF, 0xFFF. Value stays 0xFFF.
- Frame with SS_n raised after 9 SCLK rises -> frame_err 1-clk pulse; ptr and conv_cnt unchanged; next valid frame returns the previous channel's data.
- NUM_CH = 4, address 6 sent -> bad_ch = 1 (sticky) and the next frame returns 0x0000.
- rst_n low for 1 clk mid-frame -> MISO = 0, conv_cnt = 0, all values 0. The following full frame completes normally.

Source files
------------

// File: rtl/spi_adc_model_multi_pkg.sv
// Shared types and constants for the multi-channel SPI ADC behavioural model.
package adc_model_pkg;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        MODE_STATIC    = 2'b00,
        MODE_RAMP_WRAP = 2'b01,
        MODE_RAMP_SAT  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/spi_adc_model_multi_if.sv
// SPI pin bundle between the host-side master and the ADC model slave.
interface spi_adc_model_multi_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_adc_model_multi_slave_shift.sv
// SPI slave frame engine: 2-flop synchronisers, edge detect, shift registers, bit count, FSM.
// Responds 2-3 clk after a pin edge; frame_ok/frame_bad pulse in the single DONE clk.
module adc_spi_slave_shift
    import adc_model_pkg::*;
#(
    parameter int FRAME = FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic [FRAME_BITS-1:0] tx_word,
    output logic                  miso,
    output logic                  frame_start,
    output logic                  frame_ok,
    output logic                  frame_bad,
    output logic [FRAME_BITS-1:0] rx_word
);

    state_e                  state_q, state_d;
    logic [2:0]              ss_q, sclk_q;
    logic [1:0]              mosi_q;
    logic [FRAME_BITS-1:0]   tx_shift_q, rx_shift_q;
    logic [4:0]              bit_cnt_q;
    logic                    ss_fall, ss_rise, sclk_rise, sclk_fall;

    // Sync flops clear to 0 so a pin held low through reset never looks like a fresh SS_n fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[1:0], ss_n};
            sclk_q <= {sclk_q[1:0], sclk};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign ss_fall   =  ss_q[2]   & ~ss_q[1];
    assign ss_rise   = ~ss_q[2]   &  ss_q[1];
    assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
    assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (ss_rise) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Falls before the first rise are ignored so MISO presents bit 15 at the first sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
        end else if (state_q == ST_IDLE) begin
            if (ss_fall) begin
                tx_shift_q <= tx_word;
                bit_cnt_q  <= '0;
            end
        end else if (state_q == ST_SHIFT && !ss_rise) begin
            if (sclk_rise) begin
                rx_shift_q <= {rx_shift_q[FRAME_BITS-2:0], mosi_q[1]};
                if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
            end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                tx_shift_q <= {tx_shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        miso        = (state_q == ST_SHIFT) & tx_shift_q[FRAME_BITS-1];
        frame_start = (state_q == ST_IDLE) & ss_fall;
        frame_ok    = (state_q == ST_DONE) & (bit_cnt_q == 5'(FRAME));
        frame_bad   = (state_q == ST_DONE) & (bit_cnt_q != 5'(FRAME));
        rx_word     = rx_shift_q;
    end

endmodule

// File: rtl/spi_adc_model_multi.sv
// Multi-channel ADC128S-style SPI model: channel register file, ramp engine, frame counters.
// Channel addressed in frame N is returned in frame N+1; ramp applies to the channel just returned.
module spi_adc_model_multi
    import adc_model_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int RES      = 12,
    parameter int FRAME    = FRAME_BITS,
    parameter int ADDR_LSB = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_adc_model_multi_if.slave spi,
    input  logic                 ch_wr,
    input  logic [2:0]           ch_sel,
    input  logic [RES-1:0]       ch_val,
    input  logic [1:0]           ch_mode,
    input  logic [RES-1:0]       ch_step,
    output logic [15:0]          conv_cnt,
    output logic                 frame_err,
    output logic                 bad_ch
);

    logic [RES-1:0]        val_q  [NUM_CH];
    logic [RES-1:0]        val_d  [NUM_CH];
    logic [1:0]            mode_q [NUM_CH];
    logic [1:0]            mode_d [NUM_CH];
    logic [RES-1:0]        step_q [NUM_CH];
    logic [RES-1:0]        step_d [NUM_CH];
    logic [2:0]            ptr_q;
    logic [15:0]           conv_cnt_q;
    logic                  bad_ch_q;

    logic                  frame_start, frame_ok, frame_bad, miso_w, unused_rx;
    logic [FRAME_BITS-1:0] rx_word, tx_word;
    logic [2:0]            addr;
    logic                  ptr_valid, addr_valid, ramp_en;
    logic [RES-1:0]        cur_val, cur_step, ramp_val;
    logic [1:0]            cur_mode;
    logic [RES:0]          ramp_sum;

    adc_spi_slave_shift #(.FRAME(FRAME)) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .ss_n        (spi.SS_n),
        .sclk        (spi.SCLK),
        .mosi        (spi.MOSI),
        .tx_word     (tx_word),
        .miso        (miso_w),
        .frame_start (frame_start),
        .frame_ok    (frame_ok),
        .frame_bad   (frame_bad),
        .rx_word     (rx_word)
    );

    assign spi.MISO  = miso_w;
    assign addr      = rx_word[ADDR_LSB+2:ADDR_LSB];
    assign unused_rx = ^rx_word ^ frame_start;

    always_comb begin
        cur_val    = '0;
        cur_mode   = '0;
        cur_step   = '0;
        ptr_valid  = 1'b0;
        addr_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ptr_q == 3'(i)) begin
                cur_val   = val_q[i];
                cur_mode  = mode_q[i];
                cur_step  = step_q[i];
                ptr_valid = 1'b1;
            end
            if (addr == 3'(i)) addr_valid = 1'b1;
        end
    end

    // An out-of-range pointer reads as zero; tx_word is latched by the slave at SS_n fall.
    assign tx_word  = ptr_valid ? 16'(cur_val) : '0;
    assign ramp_sum = {1'b0, cur_val} + {1'b0, cur_step};

    always_comb begin
        ramp_val = ramp_sum[RES-1:0];
        if (cur_mode == MODE_RAMP_SAT && ramp_sum[RES]) ramp_val = '1;
    end

    assign ramp_en = frame_ok & ptr_valid &
                     (cur_mode == MODE_RAMP_WRAP || cur_mode == MODE_RAMP_SAT);

    always_comb begin
        val_d  = val_q;
        mode_d = mode_q;
        step_d = step_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_wr && ch_sel == 3'(i)) begin
                val_d[i]  = ch_val;
                mode_d[i] = ch_mode;
                step_d[i] = ch_step;
            end else if (ramp_en && ptr_q == 3'(i)) begin
                val_d[i] = ramp_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                val_q[i]  <= '0;
                mode_q[i] <= '0;
                step_q[i] <= '0;
            end
            ptr_q      <= '0;
            conv_cnt_q <= '0;
            bad_ch_q   <= 1'b0;
        end else begin
            val_q  <= val_d;
            mode_q <= mode_d;
            step_q <= step_d;
            if (frame_ok) begin
                ptr_q      <= addr;
                conv_cnt_q <= conv_cnt_q + 16'd1;
                if (!addr_valid) bad_ch_q <= 1'b1;
            end
        end
    end

    assign conv_cnt  = conv_cnt_q;
    assign frame_err = frame_bad;
    assign bad_ch    = bad_ch_q;

endmodule
